line_window_ctrl: RTL and testbench

//  Frame/line sequencer for the 2-line shift-RAM + 3x3 window datapath (median, Sobel, etc.).

---
 rtl/line_buf_pkg.sv | 19 +
 rtl/line_window_ctrl_if.sv | 36 +++
 rtl/edge_det.sv | 23 ++
 rtl/line_window_ctrl.sv | 163 ++++++++++++++++
 tb/tb_line_window_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/line_buf_pkg.sv
// Shared definitions for the line-buffer / 3x3 window front end.
//   COL_W_DEF   : default column counter width (line up to 2**COL_W_DEF pixels)
//   ROW_W_DEF   : default row counter width
//   WIN_LAT_DEF : accepted pixel -> win_valid latency (RAM read + matrix register)
//   lw_state_t  : frame/line sequencer states
package line_buf_pkg;

    localparam int unsigned COL_W_DEF   = 10;
    localparam int unsigned ROW_W_DEF   = 11;
    localparam int unsigned WIN_LAT_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_HBLANK    = 2'd3
    } lw_state_t;

endpackage

// File: rtl/line_window_ctrl_if.sv
// Camera timing in / line-buffer control and window status out.
//   master : camera/timing source side (drives per_frame_*)
//   slave  : line_window_ctrl side (drives lb_*, counters and window flags)
interface line_window_ctrl_if
    import line_buf_pkg::*;
#(
    parameter int unsigned COL_W = COL_W_DEF,
    parameter int unsigned ROW_W = ROW_W_DEF
);

    logic             per_frame_vsync;
    logic             per_frame_href;
    logic             per_frame_clken;
    logic             lb_href;
    logic             lb_clken;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic             win_valid;
    logic             win_border;
    logic [COL_W:0]   line_width;
    logic             width_err;
    logic             frame_done;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        input  lb_href, lb_clken, col_cnt, row_cnt, win_valid, win_border,
               line_width, width_err, frame_done
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        output lb_href, lb_clken, col_cnt, row_cnt, win_valid, win_border,
               line_width, width_err, frame_done
    );

endinterface

// File: rtl/edge_det.sv
// Single-bit edge detector.
//   clock, rst : clock and synchronous active-high reset
//   d          : level input
//   rise, fall : single-cycle pulses, combinational from d against its registered copy
module edge_det (
    input  logic clock,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clock) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/line_window_ctrl.sv
// Frame/line sequencer for the 2-line shift RAM + 3x3 window datapath.
//   clock, rst : clock and synchronous active-high reset
//   bus        : slave side of line_window_ctrl_if
//                in : per_frame_vsync/href/clken (camera timing)
//                out: lb_href/lb_clken (gated RAM controls, zero latency),
//                     col_cnt/row_cnt (position of last accepted pixel),
//                     win_valid/win_border (WIN_LAT aligned window flags),
//                     line_width/width_err/frame_done (line/frame status)
// Interface COL_W/ROW_W must match the module parameters.
module line_window_ctrl
    import line_buf_pkg::*;
#(
    parameter int unsigned COL_W   = COL_W_DEF,
    parameter int unsigned ROW_W   = ROW_W_DEF,
    parameter int unsigned WIN_LAT = WIN_LAT_DEF
) (
    input logic               clock,
    input logic               rst,
    line_window_ctrl_if.slave bus
);

    // px == PX_FULL means the line has already filled the RAM depth
    localparam logic [COL_W:0] PX_FULL = {1'b1, {COL_W{1'b0}}};

    lw_state_t          state;
    logic               vs_rise, vs_fall, hr_rise, hr_fall;
    logic               in_frame, lb_href, lb_clken;
    logic               line_end, line_has_px, px_ovf, qual, edge_px, closing;
    logic [COL_W:0]     px;          // pixels accepted so far in this line
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W:0]     width_q;
    logic [COL_W:0]     ref_w;
    logic               ref_ok;
    logic               err_q;
    logic [ROW_W-1:0]   rows_tot;    // line count of previous frame
    logic               rows_ok;
    logic               done_q;
    logic [WIN_LAT-1:0] v_sr, b_sr;

    edge_det u_vs_edge (
        .clock (clock),
        .rst   (rst),
        .d     (bus.per_frame_vsync),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    edge_det u_hr_edge (
        .clock (clock),
        .rst   (rst),
        .d     (bus.per_frame_href),
        .rise  (hr_rise),
        .fall  (hr_fall)
    );

    assign in_frame    = (state != ST_IDLE);
    assign lb_href     = bus.per_frame_href & in_frame;
    assign lb_clken    = bus.per_frame_clken & lb_href;

    assign line_end    = hr_fall & in_frame;
    assign line_has_px = (px != '0);
    assign closing     = line_end & line_has_px;
    assign px_ovf      = lb_clken & (px == PX_FULL);

    // px is the column of the pixel on the bus this cycle
    assign qual    = lb_clken & (row_q >= ROW_W'(2)) & (px >= (COL_W+1)'(2));
    assign edge_px = lb_clken & ((row_q == '0) | (px == '0)
                   | (ref_ok  & (px == ref_w - 1'b1))
                   | (rows_ok & (row_q == rows_tot - 1'b1)));

    always_ff @(posedge clock) begin
        if (rst) begin
            state    <= ST_IDLE;
            px       <= '0;
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            ref_w    <= '0;
            ref_ok   <= 1'b0;
            err_q    <= 1'b0;
            rows_tot <= '0;
            rows_ok  <= 1'b0;
            done_q   <= 1'b0;
            v_sr     <= '0;
            b_sr     <= '0;
        end else begin
            done_q  <= 1'b0;

            // Window flags are delayed per clock, independent of clken.
            v_sr[0] <= qual;
            b_sr[0] <= edge_px;
            for (int unsigned i = 1; i < WIN_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                b_sr[i] <= b_sr[i-1];
            end

            if (lb_clken) begin
                if (px_ovf) begin
                    err_q <= 1'b1;
                end else begin
                    col_q <= px[COL_W-1:0];
                    px    <= px + 1'b1;
                end
            end

            if (line_end) begin
                px    <= '0;
                col_q <= '0;
                if (line_has_px) begin
                    row_q   <= row_q + 1'b1;
                    width_q <= px;
                    if (!ref_ok) begin
                        ref_w  <= px;
                        ref_ok <= 1'b1;
                    end else if (px != ref_w) begin
                        err_q <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (vs_fall) begin
                        state  <= ST_WAIT_LINE;
                        px     <= '0;
                        col_q  <= '0;
                        row_q  <= '0;
                        err_q  <= 1'b0;
                        ref_ok <= 1'b0;
                    end
                end
                ST_WAIT_LINE, ST_ACTIVE, ST_HBLANK: begin
                    // A line closing on the vsync rise still counts toward the frame.
                    if (vs_rise) begin
                        state <= ST_IDLE;
                        if ((row_q != '0) || closing) begin
                            done_q   <= 1'b1;
                            rows_tot <= row_q + ROW_W'(closing);
                            rows_ok  <= 1'b1;
                        end
                    end else if (hr_rise) begin
                        state <= ST_ACTIVE;
                    end else if (hr_fall) begin
                        state <= ST_HBLANK;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.lb_href    = lb_href;
    assign bus.lb_clken   = lb_clken;
    assign bus.col_cnt    = col_q;
    assign bus.row_cnt    = row_q;
    assign bus.win_valid  = v_sr[WIN_LAT-1];
    assign bus.win_border = b_sr[WIN_LAT-1];
    assign bus.line_width = width_q;
    assign bus.width_err  = err_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_line_window_ctrl.sv
module tb_line_window_ctrl;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   wv_cnt = 0;
    int   fd_cnt = 0;

    always #5 clock = ~clock;

    line_window_ctrl_if #(.COL_W(10), .ROW_W(11)) bus ();

    line_window_ctrl #(.COL_W(10), .ROW_W(11), .WIN_LAT(2)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always @(negedge clock) begin
        if (bus.win_valid === 1'b1)  wv_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen at the falling edge.
    task automatic tick(input logic v, input logic h, input logic c);
        @(posedge clock);
        #1;
        bus.per_frame_vsync = v;
        bus.per_frame_href  = h;
        bus.per_frame_clken = c;
        @(negedge clock);
    endtask

    // Border of 8-wide frame pixel (r,c); lr = known last row, -1 if unknown.
    function automatic logic bord(input int r, input int c, input int lr);
        return (r == 0) || (c == 0) || (c == 7) || (r == lr);
    endfunction

    // One line of w pixels (clken every cycle) followed by 4 blank cycles.
    task automatic line(input int r, input int w, input bit chk_win,
                        input int last_row, input int short_row);
        for (int c = 0; c < w; c++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (c == 0) begin
                chk1("lb_href_on", bus.lb_href, 1'b1);
                chk1("lb_clken_on", bus.lb_clken, 1'b1);
            end
            if (chk_win) begin
                chk1("win_valid_px", bus.win_valid, (r >= 2) && (c >= 4));
                chk1("win_border_px", bus.win_border, (c >= 2) && bord(r, c - 2, last_row));
            end
        end
        for (int h = 0; h < 4; h++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (h == 0) begin
                chkn("col_cnt_eol", 32'(bus.col_cnt), w - 1);
                chkn("row_cnt_eol", 32'(bus.row_cnt), r);
                chk1("width_err_pre", bus.width_err, (short_row >= 0) && (r > short_row));
            end
            if (h == 1) begin
                chkn("col_cnt_clr", 32'(bus.col_cnt), 0);
                chkn("row_cnt_inc", 32'(bus.row_cnt), r + 1);
                chkn("line_width", 32'(bus.line_width), w);
                chk1("width_err_post", bus.width_err, (short_row >= 0) && (r >= short_row));
            end
            if (chk_win) begin
                chk1("win_valid_hb", bus.win_valid, (h < 2) && (r >= 2));
                chk1("win_border_hb", bus.win_border, (h < 2) && bord(r, w - 2 + h, last_row));
            end
        end
    endtask

    // 8x4 frame (row short_row has 7 pixels when >= 0).
    task automatic frame(input int last_row, input int short_row);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++)
            line(r, (r == short_row) ? 7 : 8, short_row < 0, last_row, short_row);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk1("frame_done_pulse", bus.frame_done, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        chk1("frame_done_single", bus.frame_done, 1'b0);
        chk1("width_err_frame_end", bus.width_err, short_row >= 0);
    endtask

    initial begin
        int wv0;
        int fd0;
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;

        // Reset with toggling timing inputs
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        chk1("rst_lb_href", bus.lb_href, 1'b0);
        chk1("rst_lb_clken", bus.lb_clken, 1'b0);
        chkn("rst_col_cnt", 32'(bus.col_cnt), 0);
        chkn("rst_row_cnt", 32'(bus.row_cnt), 0);
        chk1("rst_win_valid", bus.win_valid, 1'b0);
        chk1("rst_win_border", bus.win_border, 1'b0);
        chkn("rst_line_width", 32'(bus.line_width), 0);
        chk1("rst_width_err", bus.width_err, 1'b0);
        chk1("rst_frame_done", bus.frame_done, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // href active before any vsync fall: ignored
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            chk1("pre_vs_lb_href", bus.lb_href, 1'b0);
            chk1("pre_vs_lb_clken", bus.lb_clken, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        chkn("pre_vs_col_cnt", 32'(bus.col_cnt), 0);
        chkn("pre_vs_row_cnt", 32'(bus.row_cnt), 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chkn("pre_vs_frame_done_cnt", fd_cnt, 0);

        // 8x4 frames: first without, second with known last row
        wv0 = wv_cnt;
        frame(-1, -1);
        chkn("win_valid_count", wv_cnt - wv0, 12);
        frame(3, -1);

        // Short third line
        frame(3, 2);

        // 640-pixel lines at 50% clken; second line closes on the vsync rise
        tick(1'b0, 1'b0, 1'b0);
        chk1("width_err_held_to_fall", bus.width_err, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk1("width_err_clr_on_fall", bus.width_err, 1'b0);
        for (int i = 0; i < 1280; i++) tick(1'b0, 1'b1, (i % 2) == 0);
        chkn("col_cnt_640", 32'(bus.col_cnt), 639);
        chkn("row_cnt_640_l0", 32'(bus.row_cnt), 0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chkn("line_width_640", 32'(bus.line_width), 640);
        chkn("row_cnt_640_l1", 32'(bus.row_cnt), 1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1280; i++) tick(1'b0, 1'b1, (i % 2) == 0);
        chkn("col_cnt_640_b", 32'(bus.col_cnt), 639);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chkn("simul_row_cnt", 32'(bus.row_cnt), 2);
        chkn("simul_line_width", 32'(bus.line_width), 640);
        chk1("simul_frame_done", bus.frame_done, 1'b1);
        chk1("simul_width_err", bus.width_err, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk1("simul_frame_done_end", bus.frame_done, 1'b0);

        // Reset in the middle of line 3
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) line(r, 8, 1'b1, 1, -1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        tick(1'b0, 1'b1, 1'b1);
        chk1("mid_rst_lb_href", bus.lb_href, 1'b0);
        chk1("mid_rst_lb_clken", bus.lb_clken, 1'b0);
        chkn("mid_rst_col_cnt", 32'(bus.col_cnt), 0);
        chkn("mid_rst_row_cnt", 32'(bus.row_cnt), 0);
        chkn("mid_rst_line_width", 32'(bus.line_width), 0);
        chk1("mid_rst_width_err", bus.width_err, 1'b0);
        chk1("mid_rst_win_valid", bus.win_valid, 1'b0);
        chk1("mid_rst_win_border", bus.win_border, 1'b0);
        fd0 = fd_cnt;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chkn("mid_rst_no_frame_done", fd_cnt - fd0, 0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        line(0, 8, 1'b1, -1, -1);
        line(1, 8, 1'b1, -1, -1);
        chkn("frame_done_total", fd_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
